regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the RISC datapath: two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.
- Per-register busy (scoreboard) bit: decode sets it on issue, writeback clears it. Hazard logic can stall on an unresolved source without a separate scoreboard block.
- Sticky error flag for writes to register 0, plus a saturating count of committed writes.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = write data forwarded to read ports in the same cycle; 0 = reads see stored value only
CNT_W, 16, width of committed-write counter

Ports:
inp_clk  in  1  clock, all state updates on rising edge
inp_rst  in  1  asynchronous active-high reset
inp_rs  in  ADDR_W  read address port 1
inp_rt  in  ADDR_W  read address port 2
out_readData1  out  DATA_W  read data port 1
out_readData2  out  DATA_W  read data port 2
out_busy1  out  1  source 1 has pending write
out_busy2  out  1  source 2 has pending write
inp_flagWrite  in  1  write enable
inp_regWrite  in  ADDR_W  write destination
inp_dataWrite  in  DATA_W  write data
inp_reserve  in  1  mark destination busy (instruction issued)
inp_reserveReg  in  ADDR_W  register to reserve
inp_clearErr  in  1  clear sticky error
out_zeroWriteErr  out  1  sticky: write attempted to register 0
out_writeCount  out  CNT_W  committed writes, saturating

Behaviour:
- Reset (inp_rst=1, asynchronous, immediate):
  - All registers = 0.
  - All busy bits = 0.
  - out_zeroWriteErr = 0.
  - out_writeCount = 0.
  - Reset mid-operation discards any pending reservations.
- Reads are combinational, zero latency.
  - Address 0 always returns 0, busy 0.
  - Otherwise, if BYPASS=1 and inp_flagWrite=1 and inp_regWrite equals the read address:
    - Data = inp_dataWrite.
    - Busy = 0, unless inp_reserve targets the same register this cycle; then busy = 1.
  - Otherwise: data = stored value, busy = stored busy bit.
  - With BYPASS=0: data and busy are the stored values only; the update becomes visible the cycle after the edge.
- Write at posedge when inp_flagWrite=1:
  - inp_regWrite != 0:
    - Store inp_dataWrite.
    - Clear busy of that register.
    - Increment out_writeCount, saturating at 2**CNT_W-1.
  - inp_regWrite == 0:
    - No store, no count.
    - Set out_zeroWriteErr.
- Reserve at posedge when inp_reserve=1 and inp_reserveReg != 0: set busy of inp_reserveReg. Reserve of register 0 is ignored silently.
- Simultaneous write and reserve:
  - Same register: data is stored and busy ends at 1 (new in-flight owner wins).
  - Different registers: both take effect.
- Reserving an already-busy register leaves it busy (no nesting or count).
- Writing a non-busy register is legal (busy stays 0).
- Error flag: inp_clearErr clears it; a set in the same cycle wins over the clear.
- Both read ports may address the same register; identical outputs.
- No X propagation: every register is defined from reset.

Decomposition:
- Shared package regfile_pkg holds:
  - Default DATA_W, ADDR_W, CNT_W constants.
  - ZERO_REG = 0.
  - A function for the bypass-hit compare used by both read ports.
- One natural sub-module: regfile_read_port.
  - Mux, zero-reg forcing and bypass/busy override for a single port.
  - Instantiated twice.
- Storage, busy vector, error flag and counter stay in the top.

Test Plan:
- Reset then read all addresses:
  - out_readData1/2 = 0, out_busy1/2 = 0, out_writeCount = 0.
  - Assert inp_rst mid-test after writing r3=16'h1234: r3 reads 0 immediately, before any clock edge.
- Write r5=16'hBEEF with inp_rs=5, BYPASS=1:
  - Same cycle: out_readData1=16'hBEEF.
  - Next cycle (write deasserted): still 16'hBEEF.
  - out_writeCount=1.
  - Repeat with BYPASS=0: old value 0 during the write cycle.
- Reserve r2, then idle 3 cycles with inp_rt=2:
  - out_busy2=1 throughout.
  - Write r2=16'h0042: busy 0 the same cycle (bypass) and thereafter.
- Same-cycle write r4=16'h0007 and reserve r4:
  - Next cycle: r4 reads 16'h0007, out_busy=1.
- Write to r0 with data 16'hFFFF:
  - r0 reads 0.
  - out_zeroWriteErr=1, sticky over 5 idle cycles.
  - Same cycle of a further r0 write plus inp_clearErr: flag stays 1.
  - inp_clearErr alone: flag 0.
- CNT_W=2, perform 5 valid writes:
  - out_writeCount = 1, 2, 3, 3, 3.
  - A reserve of r0 leaves every busy output 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned ZERO_REG   = 0;

    // True when an in-flight write should be forwarded to a read port.
    function automatic logic bypass_hit(
        input logic        enable,
        input logic        flag_write,
        input logic [31:0] wr_addr,
        input logic [31:0] rd_addr
    );
        return enable && flag_write && (wr_addr == rd_addr);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, zero-register forcing and bypass/busy override.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs,
    input  logic [2**ADDR_W-1:0]                 busy_vec,
    input  logic                                 flag_write,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 reserve,
    input  logic [ADDR_W-1:0]                    reserve_reg,
    output logic [DATA_W-1:0]                    rd_data,
    output logic                                 rd_busy
);

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (addr != ADDR_W'(ZERO_REG)) begin
            if (bypass_hit(BYPASS != 0, flag_write, 32'(wr_addr), 32'(addr))) begin
                // A same-cycle reserve of this register re-arms busy behind the forwarded write.
                rd_data = wr_data;
                rd_busy = reserve && (reserve_reg == addr);
            end else begin
                rd_data = regs[addr];
                rd_busy = busy_vec[addr];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with per-register busy bits, zero-write error flag
// and a saturating committed-write counter.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              inp_clk,
    input  logic              inp_rst,
    input  logic [ADDR_W-1:0] inp_rs,
    input  logic [ADDR_W-1:0] inp_rt,
    output logic [DATA_W-1:0] out_readData1,
    output logic [DATA_W-1:0] out_readData2,
    output logic              out_busy1,
    output logic              out_busy2,
    input  logic              inp_flagWrite,
    input  logic [ADDR_W-1:0] inp_regWrite,
    input  logic [DATA_W-1:0] inp_dataWrite,
    input  logic              inp_reserve,
    input  logic [ADDR_W-1:0] inp_reserveReg,
    input  logic              inp_clearErr,
    output logic              out_zeroWriteErr,
    output logic [CNT_W-1:0]  out_writeCount
);

    logic [2**ADDR_W-1:0][DATA_W-1:0] regs;
    logic [2**ADDR_W-1:0]             busy;
    logic                             zero_err;
    logic [CNT_W-1:0]                 write_cnt;
    logic                             write_valid;
    logic                             write_zero;

    assign write_valid = inp_flagWrite && (inp_regWrite != ADDR_W'(ZERO_REG));
    assign write_zero  = inp_flagWrite && (inp_regWrite == ADDR_W'(ZERO_REG));

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            regs      <= '0;
            busy      <= '0;
            zero_err  <= 1'b0;
            write_cnt <= '0;
        end else begin
            if (write_valid) begin
                regs[inp_regWrite] <= inp_dataWrite;
                busy[inp_regWrite] <= 1'b0;
                if (write_cnt != '1)
                    write_cnt <= write_cnt + CNT_W'(1);
            end
            // Reserve is scheduled after the write so a same-register collision leaves busy set.
            if (inp_reserve && (inp_reserveReg != ADDR_W'(ZERO_REG)))
                busy[inp_reserveReg] <= 1'b1;
            if (write_zero)
                zero_err <= 1'b1;
            else if (inp_clearErr)
                zero_err <= 1'b0;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port1 (
        .addr        (inp_rs),
        .regs        (regs),
        .busy_vec    (busy),
        .flag_write  (inp_flagWrite),
        .wr_addr     (inp_regWrite),
        .wr_data     (inp_dataWrite),
        .reserve     (inp_reserve),
        .reserve_reg (inp_reserveReg),
        .rd_data     (out_readData1),
        .rd_busy     (out_busy1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port2 (
        .addr        (inp_rt),
        .regs        (regs),
        .busy_vec    (busy),
        .flag_write  (inp_flagWrite),
        .wr_addr     (inp_regWrite),
        .wr_data     (inp_dataWrite),
        .reserve     (inp_reserve),
        .reserve_reg (inp_reserveReg),
        .rd_data     (out_readData2),
        .rd_busy     (out_busy2)
    );

    assign out_zeroWriteErr = zero_err;
    assign out_writeCount   = write_cnt;

endmodule
